// File: rtl/regfile_wb_arbiter.sv
// Purpose : round-robin share of the register-file write port between two writeback requesters.
// Latency : accept at E0, wr_* registered at E1 when granted, regfile commits at E2.
// Backpr. : reqN_ready = buffer empty or being granted this cycle; a loser waits at most 1 cycle.
//
// Optional feature: define WB_BYPASS_EN to forward the registered write (wr_data)
// to a read port whose address matches, clearing that port's stall in the same cycle.
//
// Ports
//   i_clk / i_rst_n                  clock, asynchronous active-low reset
//   i_reqN_valid/addr/data, o_reqN_ready   writeback requester N (0: ALU, 1: load/multi-cycle)
//   i_rsv_valid / i_rsv_addr         issue-stage destination reservation
//   o_wr_en / o_wr_addr / o_wr_data  registered regfile write port
//   i_rd_addr_x / i_rf_rd_data_x     regfile read address and data (x = a, b)
//   o_rd_data_x / o_stall_x          read data to consumer and operand-not-ready flag
//   o_busy                           destination scoreboard
module regfile_wb_arbiter #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32,
    parameter int RR_INIT  = 0
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_req0_valid,
    input  logic [ADDR_W-1:0]   i_req0_addr,
    input  logic [DATA_W-1:0]   i_req0_data,
    output logic                o_req0_ready,
    input  logic                i_req1_valid,
    input  logic [ADDR_W-1:0]   i_req1_addr,
    input  logic [DATA_W-1:0]   i_req1_data,
    output logic                o_req1_ready,
    input  logic                i_rsv_valid,
    input  logic [ADDR_W-1:0]   i_rsv_addr,
    output logic                o_wr_en,
    output logic [ADDR_W-1:0]   o_wr_addr,
    output logic [DATA_W-1:0]   o_wr_data,
    input  logic [ADDR_W-1:0]   i_rd_addr_a,
    input  logic [ADDR_W-1:0]   i_rd_addr_b,
    input  logic [DATA_W-1:0]   i_rf_rd_data_a,
    input  logic [DATA_W-1:0]   i_rf_rd_data_b,
    output logic [DATA_W-1:0]   o_rd_data_a,
    output logic [DATA_W-1:0]   o_rd_data_b,
    output logic                o_stall_a,
    output logic                o_stall_b,
    output logic [NUM_REGS-1:0] o_busy
);

    // Holding buffers, one entry per requester
    logic                r_full0;
    logic [ADDR_W-1:0]   r_addr0;
    logic [DATA_W-1:0]   r_data0;
    logic                r_full1;
    logic [ADDR_W-1:0]   r_addr1;
    logic [DATA_W-1:0]   r_data1;

    // Round-robin pointer: requester favoured when both buffers are full
    logic                r_rr;

    // Registered write port
    logic                r_wr_en;
    logic [ADDR_W-1:0]   r_wr_addr;
    logic [DATA_W-1:0]   r_wr_data;

    logic [NUM_REGS-1:0] r_busy;
    logic [NUM_REGS-1:0] w_busy_nxt;

    logic w_gnt0, w_gnt1;
    logic w_acc0, w_acc1;
    logic w_sb_a, w_sb_b;
    logic w_fwd_a, w_fwd_b;

    // A lone full buffer always wins; contention resolved by the pointer.
    assign w_gnt0 = r_full0 && (!r_full1 || !r_rr);
    assign w_gnt1 = r_full1 && (!r_full0 ||  r_rr);

    // A buffer being drained this cycle may be refilled on the same edge.
    assign o_req0_ready = !r_full0 || w_gnt0;
    assign o_req1_ready = !r_full1 || w_gnt1;
    assign w_acc0       = i_req0_valid && o_req0_ready;
    assign w_acc1       = i_req1_valid && o_req1_ready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_full0 <= 1'b0;
            r_addr0 <= '0;
            r_data0 <= '0;
            r_full1 <= 1'b0;
            r_addr1 <= '0;
            r_data1 <= '0;
        end else begin
            if (w_acc0) begin
                r_full0 <= 1'b1;
                r_addr0 <= i_req0_addr;
                r_data0 <= i_req0_data;
            end else if (w_gnt0) begin
                r_full0 <= 1'b0;
            end
            if (w_acc1) begin
                r_full1 <= 1'b1;
                r_addr1 <= i_req1_addr;
                r_data1 <= i_req1_data;
            end else if (w_gnt1) begin
                r_full1 <= 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rr      <= (RR_INIT != 0);
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            // Pointer only moves on contention, so the loser is served next.
            if (r_full0 && r_full1) begin
                r_rr <= ~r_rr;
            end
            r_wr_en <= w_gnt0 || w_gnt1;
            if (w_gnt0) begin
                r_wr_addr <= r_addr0;
                r_wr_data <= r_data0;
            end else if (w_gnt1) begin
                r_wr_addr <= r_addr1;
                r_wr_data <= r_data1;
            end
        end
    end

    // Scoreboard: clear on the commit edge, then a same-edge reservation
    // re-sets the bit because it belongs to a newer producer.
    always_comb begin
        w_busy_nxt = r_busy;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (r_wr_en && (r_wr_addr == ADDR_W'(i))) begin
                w_busy_nxt[i] = 1'b0;
            end
            if (i_rsv_valid && (i_rsv_addr == ADDR_W'(i))) begin
                w_busy_nxt[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    // Scoreboard lookup; addresses outside the tracked range read as not busy.
    always_comb begin
        w_sb_a = 1'b0;
        w_sb_b = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (i_rd_addr_a == ADDR_W'(i)) begin
                w_sb_a = r_busy[i];
            end
            if (i_rd_addr_b == ADDR_W'(i)) begin
                w_sb_b = r_busy[i];
            end
        end
    end

`ifdef WB_BYPASS_EN
    assign w_fwd_a = r_wr_en && (r_wr_addr == i_rd_addr_a);
    assign w_fwd_b = r_wr_en && (r_wr_addr == i_rd_addr_b);
`else
    assign w_fwd_a = 1'b0;
    assign w_fwd_b = 1'b0;
`endif

    assign o_rd_data_a = w_fwd_a ? r_wr_data : i_rf_rd_data_a;
    assign o_rd_data_b = w_fwd_b ? r_wr_data : i_rf_rd_data_b;
    assign o_stall_a   = w_sb_a && !w_fwd_a;
    assign o_stall_b   = w_sb_b && !w_fwd_b;

    assign o_wr_en   = r_wr_en;
    assign o_wr_addr = r_wr_addr;
    assign o_wr_data = r_wr_data;
    assign o_busy    = r_busy;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic [4:0]  req0_addr, req1_addr;
    logic [31:0] req0_data, req1_data;
    logic        req0_ready, req1_ready;
    logic        rsv_valid;
    logic [4:0]  rsv_addr;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [4:0]  rd_addr_a, rd_addr_b;
    logic [31:0] rf_rd_data_a, rf_rd_data_b;
    logic [31:0] rd_data_a, rd_data_b;
    logic        stall_a, stall_b;
    logic [31:0] busy;

    regfile_wb_arbiter #(
        .NUM_REGS(32), .ADDR_W(5), .DATA_W(32), .RR_INIT(0)
    ) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_req0_valid   (req0_valid),
        .i_req0_addr    (req0_addr),
        .i_req0_data    (req0_data),
        .o_req0_ready   (req0_ready),
        .i_req1_valid   (req1_valid),
        .i_req1_addr    (req1_addr),
        .i_req1_data    (req1_data),
        .o_req1_ready   (req1_ready),
        .i_rsv_valid    (rsv_valid),
        .i_rsv_addr     (rsv_addr),
        .o_wr_en        (wr_en),
        .o_wr_addr      (wr_addr),
        .o_wr_data      (wr_data),
        .i_rd_addr_a    (rd_addr_a),
        .i_rd_addr_b    (rd_addr_b),
        .i_rf_rd_data_a (rf_rd_data_a),
        .i_rf_rd_data_b (rf_rd_data_b),
        .o_rd_data_a    (rd_data_a),
        .o_rd_data_b    (rd_data_b),
        .o_stall_a      (stall_a),
        .o_stall_b      (stall_b),
        .o_busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: pending write per requester, the requester that wins
    // the next tie, the write presented to the regfile, and reserved registers.
    logic        m_pend  [2];
    logic [4:0]  m_paddr [2];
    logic [31:0] m_pdata [2];
    int          m_favour;
    logic        m_wen;
    logic [4:0]  m_waddr;
    logic [31:0] m_wdata;
    logic [31:0] m_busy;

    // Values observed in the most recent step, for directed literal checks
    logic        obs_rdy0, obs_rdy1, obs_stall_a;
    logic [31:0] obs_rd_a;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_pend[0] = 1'b0; m_pend[1] = 1'b0;
        m_favour  = 0;
        m_wen     = 1'b0;
        m_waddr   = '0;
        m_wdata   = '0;
        m_busy    = '0;
    endtask

    // Entered and left at a negedge; one clock per call.
    task automatic step(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                        input logic v1, input logic [4:0] a1, input logic [31:0] d1,
                        input logic rv, input logic [4:0] ra,
                        input logic [4:0] rda, input logic [4:0] rdb);
        int          winner;
        logic        rdy [2];
        logic        exp_st_a, exp_st_b;
        logic [31:0] exp_rd_a, exp_rd_b;
        logic [31:0] fa, fb;
        fa = $urandom; fb = $urandom;
        req0_valid = v0; req0_addr = a0; req0_data = d0;
        req1_valid = v1; req1_addr = a1; req1_data = d1;
        rsv_valid  = rv; rsv_addr  = ra;
        rd_addr_a  = rda; rd_addr_b = rdb;
        rf_rd_data_a = fa; rf_rd_data_b = fb;
        #1;
        // Which pending write goes out this cycle (-1: none)
        if (m_pend[0] && m_pend[1]) winner = m_favour;
        else if (m_pend[0])         winner = 0;
        else if (m_pend[1])         winner = 1;
        else                        winner = -1;
        for (int r = 0; r < 2; r++) rdy[r] = !m_pend[r] || (winner == r);
        exp_st_a = m_busy[rda]; exp_rd_a = fa;
        exp_st_b = m_busy[rdb]; exp_rd_b = fb;
`ifdef WB_BYPASS_EN
        if (m_wen && m_waddr == rda) begin exp_st_a = 1'b0; exp_rd_a = m_wdata; end
        if (m_wen && m_waddr == rdb) begin exp_st_b = 1'b0; exp_rd_b = m_wdata; end
`endif
        chk("req0_ready", {63'b0, req0_ready}, {63'b0, rdy[0]});
        chk("req1_ready", {63'b0, req1_ready}, {63'b0, rdy[1]});
        chk("stall_a", {63'b0, stall_a}, {63'b0, exp_st_a});
        chk("stall_b", {63'b0, stall_b}, {63'b0, exp_st_b});
        chk("rd_data_a", {32'b0, rd_data_a}, {32'b0, exp_rd_a});
        chk("rd_data_b", {32'b0, rd_data_b}, {32'b0, exp_rd_b});
        obs_rdy0 = req0_ready; obs_rdy1 = req1_ready;
        obs_stall_a = stall_a; obs_rd_a = rd_data_a;
        @(posedge clk);
        // Commit of the presented write frees its register; a new reservation wins.
        if (m_wen) m_busy[m_waddr] = 1'b0;
        if (rv)    m_busy[ra] = 1'b1;
        if (m_pend[0] && m_pend[1]) m_favour = 1 - m_favour;
        m_wen = (winner >= 0);
        if (winner >= 0) begin
            m_waddr = m_paddr[winner];
            m_wdata = m_pdata[winner];
            m_pend[winner] = 1'b0;
        end
        if (v0 && rdy[0]) begin m_pend[0] = 1'b1; m_paddr[0] = a0; m_pdata[0] = d0; end
        if (v1 && rdy[1]) begin m_pend[1] = 1'b1; m_paddr[1] = a1; m_pdata[1] = d1; end
        @(negedge clk);
        chk("wr_en", {63'b0, wr_en}, {63'b0, m_wen});
        if (m_wen) begin
            chk("wr_addr", {59'b0, wr_addr}, {59'b0, m_waddr});
            chk("wr_data", {32'b0, wr_data}, {32'b0, m_wdata});
        end
        chk("busy", {32'b0, busy}, {32'b0, m_busy});
    endtask

    task automatic idle(input logic [4:0] rda);
        step(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 0, 5'd0, rda, 5'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req0_valid = 0; req1_valid = 0; rsv_valid = 0;
        #1;
        model_reset();
        @(negedge clk);
        chk("reset wr_en", {63'b0, wr_en}, 64'd0);
        chk("reset wr_addr", {59'b0, wr_addr}, 64'd0);
        chk("reset wr_data", {32'b0, wr_data}, 64'd0);
        chk("reset busy", {32'b0, busy}, 64'd0);
        chk("reset readys", {62'b0, req0_ready, req1_ready}, 64'd3);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        req0_valid = 0; req0_addr = 0; req0_data = 0;
        req1_valid = 0; req1_addr = 0; req1_data = 0;
        rsv_valid = 0; rsv_addr = 0;
        rd_addr_a = 0; rd_addr_b = 0; rf_rd_data_a = 0; rf_rd_data_b = 0;
        model_reset();
        @(negedge clk);
        do_reset();

        // Single write from requester 0
        step(1, 5'd5, 32'hDEAD_BEEF, 0, 5'd0, 32'd0, 0, 5'd0, 5'd0, 5'd0);
        chk("r5 not yet out", {63'b0, wr_en}, 64'd0);
        idle(5'd0);
        chk("r5 wr_en", {63'b0, wr_en}, 64'd1);
        chk("r5 wr_addr", {59'b0, wr_addr}, 64'd5);
        chk("r5 wr_data", {32'b0, wr_data}, 64'hDEAD_BEEF);

        // Both requesters streaming: alternate grants and readies
        do_reset();
        for (int k = 0; k < 7; k++) begin
            step(1, 5'd1, 32'h100 + k, 1, 5'd2, 32'h200 + k, 0, 5'd0, 5'd0, 5'd0);
            if (k >= 1) begin
                chk("rr ready0", {63'b0, obs_rdy0}, {63'b0, k[0]});
                chk("rr ready1", {63'b0, obs_rdy1}, {63'b0, !k[0]});
                chk("rr grant", {59'b0, wr_addr}, k[0] ? 64'd1 : 64'd2);
            end
        end

        // Same destination from both in one cycle: req0 first, req1 last
        do_reset();
        step(1, 5'd7, 32'h11, 1, 5'd7, 32'h22, 0, 5'd0, 5'd0, 5'd0);
        idle(5'd0);
        chk("r7 first", {27'b0, wr_en, wr_addr, wr_data}, {27'b0, 1'b1, 5'd7, 32'h11});
        idle(5'd0);
        chk("r7 second", {27'b0, wr_en, wr_addr, wr_data}, {27'b0, 1'b1, 5'd7, 32'h22});

        // Reserved r9 stalls its reader until the commit edge
        do_reset();
        step(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 1, 5'd9, 5'd9, 5'd0);
        step(1, 5'd9, 32'hABCD, 0, 5'd0, 32'd0, 0, 5'd0, 5'd9, 5'd0);
        chk("r9 stall reserved", {63'b0, obs_stall_a}, 64'd1);
        idle(5'd9);
        chk("r9 stall before wr", {63'b0, obs_stall_a}, 64'd1);
        idle(5'd9);
`ifdef WB_BYPASS_EN
        chk("r9 bypass stall", {63'b0, obs_stall_a}, 64'd0);
        chk("r9 bypass data", {32'b0, obs_rd_a}, 64'hABCD);
`else
        chk("r9 stall at wr", {63'b0, obs_stall_a}, 64'd1);
`endif
        idle(5'd9);
        chk("r9 stall released", {63'b0, obs_stall_a}, 64'd0);

        // Reservation on the commit edge of the same register keeps it busy
        do_reset();
        step(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 1, 5'd3, 5'd0, 5'd0);
        step(1, 5'd3, 32'h33, 0, 5'd0, 32'd0, 0, 5'd0, 5'd0, 5'd0);
        idle(5'd0);
        step(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 1, 5'd3, 5'd0, 5'd0);
        chk("r3 set wins", {63'b0, busy[3]}, 64'd1);
        step(0, 5'd0, 32'd0, 1, 5'd3, 32'h44, 0, 5'd0, 5'd0, 5'd0);
        idle(5'd0);
        idle(5'd0);
        chk("r3 cleared", {63'b0, busy[3]}, 64'd0);

        // Randomised traffic, with an asynchronous reset part-way through
        for (int c = 0; c < 3000; c++) begin
            step($urandom_range(0, 9) < 7, 5'($urandom_range(0, 7)), $urandom,
                 $urandom_range(0, 9) < 7, 5'($urandom_range(0, 7)), $urandom,
                 $urandom_range(0, 9) < 4, 5'($urandom_range(0, 7)),
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            if (c == 1500) begin
                #3;
                rst_n = 1'b0;
                #1;
                chk("async rst wr_en", {63'b0, wr_en}, 64'd0);
                chk("async rst busy", {32'b0, busy}, 64'd0);
                chk("async rst readys", {62'b0, req0_ready, req1_ready}, 64'd3);
                model_reset();
                @(negedge clk);
                rst_n = 1'b1;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
